i3c_phy_bus_sequencer: RTL and testbench

- Bit-level bus sequencer that drives the I3C PHY's controller-side inputs: SCL, SDA and the OD/PP select.
- Turns one-command-at-a-time requests (START/Sr, STOP, WRITE bit, READ bit) into timed SCL/SDA waveforms.
- Samples the synchronized bus lines coming back from the PHY, and reports the read bit and any arbitration loss.
- Sits between the controller's byte/frame FSM and the PHY.

---
 rtl/i3c_phy_bus_sequencer.sv | 147 ++++++++++++++
 tb/tb_i3c_phy_bus_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/i3c_phy_bus_sequencer.sv
// Bit-level I3C controller bus sequencer: turns START/STOP/WRITE/READ requests into
// timed SCL/SDA drive, with clock stretching, read sampling and arbitration detection.
module i3c_phy_bus_sequencer #(
  parameter int CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [2:0]      cmd_op_i,
  input  logic            cmd_bit_i,
  input  logic            cmd_pp_i,
  input  logic [CntW-1:0] t_low_i,
  input  logic [CntW-1:0] t_high_i,
  input  logic [CntW-1:0] t_su_i,
  input  logic [CntW-1:0] t_hd_i,
  input  logic            phy_scl_i,
  input  logic            phy_sda_i,
  output logic            phy_scl_o,
  output logic            phy_sda_o,
  output logic            phy_sel_od_pp_o,
  output logic            rsp_valid_o,
  output logic            rsp_bit_o,
  output logic            rsp_err_o,
  output logic            busy_o
);
  typedef enum logic [3:0] {
    IDLE, S_REL, S_SU, S_HD, P_LOW, P_SU, P_HD, B_LOW, B_HIGH, DONE
  } state_t;

  localparam logic [2:0] OP_START = 3'd1, OP_STOP = 3'd2, OP_WRITE = 3'd3, OP_READ = 3'd4;

  state_t          state_q, state_n;
  logic [CntW-1:0] cnt_q, cnt_n, t_high_q, t_su_q, t_hd_q;
  logic            arb_en_q, smp_q, smp_n, arb_q, arb_n;
  logic            scl_n, sda_n, od_n, rv_n, rb_n, re_n;
  logic            accept, stall, last;

  // Phase counter load value: a zero timing value still yields a one-cycle phase.
  function automatic logic [CntW-1:0] ld(input logic [CntW-1:0] t);
    return (t == '0) ? '0 : t - CntW'(1);
  endfunction

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = ~cmd_ready_o;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    scl_n   = phy_scl_o;
    sda_n   = phy_sda_o;
    od_n    = phy_sel_od_pp_o;
    rv_n    = 1'b0;
    rb_n    = rsp_bit_o;
    re_n    = rsp_err_o;
    smp_n   = smp_q;
    arb_n   = arb_q;
    accept  = 1'b0;
    // A target holding SCL low freezes the high phase; push-pull ignores the line.
    stall   = (state_q == B_HIGH || state_q == S_SU) && !phy_sel_od_pp_o && !phy_scl_i;
    last    = (cnt_q == '0) && !stall;
    if (state_q != IDLE && state_q != DONE && !stall && cnt_q != '0) cnt_n = cnt_q - CntW'(1);

    case (state_q)
      IDLE: if (cmd_valid_i) begin
        accept = 1'b1;
        smp_n  = 1'b0;
        arb_n  = 1'b0;
        case (cmd_op_i)
          OP_START: begin
            od_n = 1'b0;
            if (phy_scl_o) begin
              state_n = S_SU; cnt_n = ld(t_su_i); scl_n = 1'b1; sda_n = 1'b1;
            end else begin
              state_n = S_REL; cnt_n = ld(t_low_i); sda_n = 1'b1;
            end
          end
          OP_STOP: begin
            od_n = 1'b0; state_n = P_LOW; cnt_n = ld(t_low_i); scl_n = 1'b0; sda_n = 1'b0;
          end
          OP_WRITE: begin
            od_n = cmd_pp_i; state_n = B_LOW; cnt_n = ld(t_low_i); scl_n = 1'b0; sda_n = cmd_bit_i;
          end
          OP_READ: begin
            od_n = 1'b0; state_n = B_LOW; cnt_n = ld(t_low_i); scl_n = 1'b0; sda_n = 1'b1;
          end
          default: begin
            rv_n = 1'b1; rb_n = 1'b0; re_n = 1'b1;
          end
        endcase
      end
      S_REL:  if (last) begin state_n = S_SU; cnt_n = ld(t_su_q); scl_n = 1'b1; sda_n = 1'b1; end
      S_SU:   if (last) begin state_n = S_HD; cnt_n = ld(t_hd_q); sda_n = 1'b0; end
      S_HD:   if (last) begin state_n = DONE; scl_n = 1'b0; end
      P_LOW:  if (last) begin state_n = P_SU; cnt_n = ld(t_su_q); scl_n = 1'b1; end
      P_SU:   if (last) begin state_n = P_HD; cnt_n = ld(t_hd_q); sda_n = 1'b1; end
      P_HD:   if (last) state_n = DONE;
      B_LOW:  if (last) begin state_n = B_HIGH; cnt_n = ld(t_high_q); scl_n = 1'b1; end
      B_HIGH: if (last) begin
        state_n = DONE;
        scl_n   = 1'b0;
        smp_n   = phy_sda_i;
        arb_n   = arb_en_q & ~phy_sda_i;
      end
      DONE: begin
        state_n = IDLE; rv_n = 1'b1; rb_n = smp_q; re_n = arb_q;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      t_high_q        <= '0;
      t_su_q          <= '0;
      t_hd_q          <= '0;
      arb_en_q        <= 1'b0;
      smp_q           <= 1'b0;
      arb_q           <= 1'b0;
      phy_scl_o       <= 1'b1;
      phy_sda_o       <= 1'b1;
      phy_sel_od_pp_o <= 1'b0;
      rsp_valid_o     <= 1'b0;
      rsp_bit_o       <= 1'b0;
      rsp_err_o       <= 1'b0;
    end else begin
      state_q         <= state_n;
      cnt_q           <= cnt_n;
      smp_q           <= smp_n;
      arb_q           <= arb_n;
      phy_scl_o       <= scl_n;
      phy_sda_o       <= sda_n;
      phy_sel_od_pp_o <= od_n;
      rsp_valid_o     <= rv_n;
      rsp_bit_o       <= rb_n;
      rsp_err_o       <= re_n;
      if (accept) begin
        t_high_q <= t_high_i;
        t_su_q   <= t_su_i;
        t_hd_q   <= t_hd_i;
        arb_en_q <= (cmd_op_i == OP_WRITE) && cmd_bit_i && !cmd_pp_i;
      end
    end
  end
endmodule

// File: tb/tb_i3c_phy_bus_sequencer.sv
// Bench for i3c_phy_bus_sequencer: table vectors, stretch/reset sequences and random
// commands checked against a per-cycle waveform model built from the phase rules.
module tb_i3c_phy_bus_sequencer;
  localparam int CntW = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            cmd_valid_i = 1'b0;
  logic            cmd_ready_o;
  logic [2:0]      cmd_op_i = '0;
  logic            cmd_bit_i = 1'b0;
  logic            cmd_pp_i = 1'b0;
  logic [CntW-1:0] t_low_i = '0, t_high_i = '0, t_su_i = '0, t_hd_i = '0;
  logic            phy_scl_i, phy_sda_i;
  logic            phy_scl_o, phy_sda_o, phy_sel_od_pp_o;
  logic            rsp_valid_o, rsp_bit_o, rsp_err_o, busy_o;
  logic            scl_hold = 1'b0, sda_pull = 1'b0;

  // Wired-AND bus: a target can only pull lines low.
  assign phy_scl_i = phy_scl_o & ~scl_hold;
  assign phy_sda_i = phy_sda_o & ~sda_pull;

  i3c_phy_bus_sequencer #(.CntW(CntW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_bit_i(cmd_bit_i), .cmd_pp_i(cmd_pp_i),
    .t_low_i(t_low_i), .t_high_i(t_high_i), .t_su_i(t_su_i), .t_hd_i(t_hd_i),
    .phy_scl_i(phy_scl_i), .phy_sda_i(phy_sda_i), .phy_scl_o(phy_scl_o), .phy_sda_o(phy_sda_o),
    .phy_sel_od_pp_o(phy_sel_od_pp_o), .rsp_valid_o(rsp_valid_o), .rsp_bit_o(rsp_bit_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0] op;
    bit         b, pp;
    int         tl, th, tsu, thd;
    int         pull;
    bit         eb, ee;
  } vec_t;

  int checks = 0, failures = 0;
  bit e_scl = 1'b1, e_sda = 1'b1, e_od = 1'b0, e_rb = 1'b0, e_re = 1'b0;

  function automatic logic [7:0] obs();
    return {phy_scl_o, phy_sda_o, phy_sel_od_pp_o, rsp_valid_o, busy_o, cmd_ready_o, rsp_bit_o, rsp_err_o};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual{scl,sda,od,vld,busy,rdy,bit,err}=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int nph(input int t);
    return (t == 0) ? 1 : t;
  endfunction

  // Builds the expected per-cycle {scl,sda} trace, drives the command, compares every
  // cycle, then checks the response. pull: 0 none, 1 whole command, 2 random per cycle.
  task automatic run_cmd(input logic [2:0] op, input bit b, input bit pp, input int tl,
                         input int th, input int tsu, input int thd, input int pull,
                         input bit use_tbl, input bit tb_bit, input bit tb_err, input string name);
    logic [1:0] tr[$];
    bit od, bb, lp, samp;
    int hi_idx;
    od = e_od; hi_idx = -1; lp = 1'b0; bb = 1'b1;
    case (op)
      3'd1: begin
        od = 1'b0;
        if (!e_scl) repeat (nph(tl)) tr.push_back({1'b0, 1'b1});
        repeat (nph(tsu)) tr.push_back(2'b11);
        repeat (nph(thd)) tr.push_back(2'b10);
        tr.push_back(2'b00);
      end
      3'd2: begin
        od = 1'b0;
        repeat (nph(tl)) tr.push_back(2'b00);
        repeat (nph(tsu)) tr.push_back(2'b10);
        repeat (nph(thd)) tr.push_back(2'b11);
        tr.push_back(2'b11);
      end
      3'd3, 3'd4: begin
        bb = (op == 3'd3) ? b : 1'b1;
        od = (op == 3'd3) ? pp : 1'b0;
        repeat (nph(tl)) tr.push_back({1'b0, bb});
        repeat (nph(th)) tr.push_back({1'b1, bb});
        hi_idx = tr.size() - 1;
        tr.push_back({1'b0, bb});
      end
      default: ;
    endcase
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_bit_i = b; cmd_pp_i = pp;
    t_low_i = CntW'(tl); t_high_i = CntW'(th); t_su_i = CntW'(tsu); t_hd_i = CntW'(thd);
    step();
    cmd_valid_i = 1'b0; cmd_op_i = 3'($urandom_range(0, 7));
    t_low_i = CntW'($urandom_range(0, 9)); t_high_i = CntW'($urandom_range(0, 9));
    t_su_i = CntW'($urandom_range(0, 9)); t_hd_i = CntW'($urandom_range(0, 9));
    for (int i = 0; i < tr.size(); i++) begin
      sda_pull = (pull == 1) ? 1'b1 : (pull == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == hi_idx) lp = sda_pull;
      chk({name, "_phase"}, obs(), {tr[i], od, 1'b0, 1'b1, 1'b0, e_rb, e_re});
      step();
    end
    sda_pull = 1'b0;
    if (op == 3'd3 || op == 3'd4) begin
      samp = bb & ~lp;
      e_rb = samp;
      e_re = (op == 3'd3) && b && !pp && !samp;
    end else if (op == 3'd1 || op == 3'd2) begin
      e_rb = 1'b0; e_re = 1'b0;
    end else begin
      e_rb = 1'b0; e_re = 1'b1;
    end
    if (use_tbl) begin e_rb = tb_bit; e_re = tb_err; end
    if (tr.size() > 0) {e_scl, e_sda} = tr[tr.size()-1];
    e_od = od;
    chk({name, "_rsp"}, obs(), {e_scl, e_sda, e_od, 1'b1, 1'b0, 1'b1, e_rb, e_re});
  endtask

  initial begin
    vec_t tbl[11];
    int hi;
    bit ended;
    tbl[0]  = '{3'd1, 0, 0, 2, 2, 4, 3, 0, 0, 0}; // START from idle, S_REL skipped
    tbl[1]  = '{3'd3, 1, 1, 5, 5, 1, 1, 1, 0, 0}; // push-pull write, line pulled: no arb
    tbl[2]  = '{3'd3, 1, 0, 3, 3, 1, 1, 1, 0, 1}; // open-drain write lost arbitration
    tbl[3]  = '{3'd4, 0, 1, 2, 3, 1, 1, 0, 1, 0}; // read released line
    tbl[4]  = '{3'd3, 0, 0, 1, 2, 1, 1, 0, 0, 0};
    tbl[5]  = '{3'd1, 0, 0, 3, 1, 2, 2, 0, 0, 0}; // repeated START with SCL low
    tbl[6]  = '{3'd3, 0, 1, 2, 2, 1, 1, 0, 0, 0};
    tbl[7]  = '{3'd7, 1, 0, 4, 4, 4, 4, 0, 0, 1}; // illegal opcode
    tbl[8]  = '{3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // STOP with zero timings
    tbl[9]  = '{3'd0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
    tbl[10] = '{3'd4, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    repeat (3) step();
    chk("reset_state", obs(), 8'b1100_0100);
    rst_ni = 1'b1;
    step();
    chk("idle_after_reset", obs(), 8'b1100_0100);

    for (int v = 0; v < 11; v++)
      run_cmd(tbl[v].op, tbl[v].b, tbl[v].pp, tbl[v].tl, tbl[v].th, tbl[v].tsu, tbl[v].thd,
              tbl[v].pull, 1'b1, tbl[v].eb, tbl[v].ee, $sformatf("tbl%0d", v));

    // Clock stretching: target holds SCL low for the first 6 high cycles of a READ.
    step();
    cmd_valid_i = 1'b1; cmd_op_i = 3'd4; t_low_i = 2; t_high_i = 4; scl_hold = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    hi = 0; ended = 1'b0;
    for (int c = 0; c < 40 && !ended; c++) begin
      if (phy_scl_o) begin
        hi++;
        scl_hold = (hi <= 6);
        sda_pull = (hi == 10);
        step();
      end else if (hi > 0) ended = 1'b1;
      else step();
    end
    scl_hold = 1'b0; sda_pull = 1'b0;
    checks++;
    if (hi != 10) begin
      failures++;
      $display("FAIL stretch_len actual=%0d required=10", hi);
    end
    chk("stretch_done", obs(), 8'b0100_1000);
    step();
    chk("stretch_rsp", obs(), 8'b0101_0100);
    e_scl = 0; e_sda = 1; e_od = 0; e_rb = 0; e_re = 0;

    // Asynchronous reset in the middle of a WRITE high phase.
    cmd_valid_i = 1'b1; cmd_op_i = 3'd3; cmd_bit_i = 1'b0; cmd_pp_i = 1'b1;
    t_low_i = 2; t_high_i = 8;
    step();
    cmd_valid_i = 1'b0;
    repeat (3) step();
    chk("pre_reset_high", obs(), 8'b1010_1000);
    #2 rst_ni = 1'b0;
    #1 chk("async_reset", obs(), 8'b1100_0100);
    #2 rst_ni = 1'b1;
    repeat (3) begin
      step();
      chk("post_reset_idle", obs(), 8'b1100_0100);
    end
    e_scl = 1; e_sda = 1; e_od = 0; e_rb = 0; e_re = 0;

    for (int n = 0; n < 40; n++) begin
      int r;
      logic [2:0] op;
      r = $urandom_range(0, 9);
      op = (r < 9) ? 3'(r % 4 + 1) : (($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(5, 7)));
      run_cmd(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), 2, 1'b0, 1'b0, 1'b0, $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) begin
        step();
        chk("rnd_gap", obs(), {e_scl, e_sda, e_od, 1'b0, 1'b0, 1'b1, e_rb, e_re});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
